// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the byte-enable dual-port RAM family.
package dpram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int rd_latency(input int out_reg);
    return 1 + out_reg;
  endfunction

  function automatic int num_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dpram_be_core.sv
// Byte-enable memory array with a registered read, an optional output
// register stage and a same-address read-during-write bypass. A valid bit
// travels with the data so the caller knows when a read word arrives.
module dpram_be_core
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 1,
  parameter int RDW_MODE   = RDW_OLD,
  localparam int NB        = num_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NB-1:0]         wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  // Lane-masked write; the array is intentionally never reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read word, optionally merged with a same-address write landing on the same edge.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == RDW_NEW && wr_en && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // First read stage: the RAM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    // Optional second stage to ease timing on the read path.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
  end else begin : g_no_out_reg
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
  end

endmodule

// File: rtl/dpram_rd_stream.sv
// Dual-port RAM with a valid/ready read port. Requests are throttled by an
// outstanding counter so that every accepted read always has a slot in the
// result FIFO, which means back-pressure can never drop a word.
module dpram_rd_stream
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 1,
  parameter int RDW_MODE   = RDW_OLD,
  localparam int NB        = num_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NB-1:0]         wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int L  = rd_latency(OUT_REG);
  localparam int D  = L + 1;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("dpram_rd_stream: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic                  core_valid;
  logic [DATA_WIDTH-1:0] core_data;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  buf_pop;
  logic                  buf_empty;
  logic [CW-1:0]         out_cnt;
  logic [CW-1:0]         buf_cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] buf_mem [D];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  dpram_be_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .OUT_REG    (OUT_REG),
    .RDW_MODE   (RDW_MODE)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_en     (accept),
    .rd_addr   (rd_addr),
    .out_valid (core_valid),
    .out_data  (core_data)
  );

  // The FIFO is fall-through: a word leaving the pipeline into an empty FIFO is
  // presented directly, and only parked in a register if the consumer stalls.
  assign rd_req_ready = !rst && (out_cnt < CW'(D));
  assign accept       = rd_req_valid && rd_req_ready;
  assign buf_empty    = (buf_cnt == '0);
  assign rd_valid     = !rst && (!buf_empty || core_valid);
  assign rd_data      = buf_empty ? core_data : buf_mem[rd_ptr];
  assign pop          = rd_valid && rd_ready;
  assign push         = core_valid && !(buf_empty && pop);
  assign buf_pop      = pop && !buf_empty;

  // Outstanding reads: accepted but not yet consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Result FIFO pointers and occupancy; reset discards anything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (push)    wr_ptr <= ptr_next(wr_ptr);
      if (buf_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, buf_pop})
        2'b10:   buf_cnt <= buf_cnt + CW'(1);
        2'b01:   buf_cnt <= buf_cnt - CW'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Result FIFO storage; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= core_data;
  end

endmodule

// File: tb/tb_dpram_rd_stream.sv
// Bench for dpram_rd_stream. Two instances: OUT_REG=1/old-data and
// OUT_REG=0/new-data, exercised one after the other with the same suite.
module tb_dpram_rd_stream;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst;
  logic [1:0]         wr_en;
  logic [1:0][AW-1:0] wr_addr;
  logic [1:0][NB-1:0] wr_be;
  logic [1:0][DW-1:0] wr_data;
  logic [1:0]         rd_req_valid;
  logic [1:0]         rd_req_ready;
  logic [1:0][AW-1:0] rd_addr;
  logic [1:0]         rd_valid;
  logic [1:0]         rd_ready;
  logic [1:0][DW-1:0] rd_data;

  dpram_rd_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .OUT_REG(1), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_be(wr_be[0]),
    .wr_data(wr_data[0]), .rd_req_valid(rd_req_valid[0]), .rd_req_ready(rd_req_ready[0]),
    .rd_addr(rd_addr[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_data(rd_data[0])
  );

  dpram_rd_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .OUT_REG(0), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_be(wr_be[1]),
    .wr_data(wr_data[1]), .rd_req_valid(rd_req_valid[1]), .rd_req_ready(rd_req_ready[1]),
    .rd_addr(rd_addr[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_data(rd_data[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: one queue of expected words per instance, plus a memory model
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] mm [2][16];
  int          pops [2] = '{0, 0};
  logic [1:0]  prev_hold = '0;

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void q_push(input int k, input logic [31:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  function automatic logic [31:0] q_front(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_drop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void q_clear(input int k);
    if (k == 0) q0.delete();
    else        q1.delete();
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // monitor: sampled mid-cycle, sees exactly what the next rising edge will act on
  always @(negedge clk) begin : mon
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        q_clear(k);
        prev_hold[k] = 1'b0;
        check_eq("rst_rd_valid", 32'(rd_valid[k]), 0);
        check_eq("rst_req_ready", 32'(rd_req_ready[k]), 0);
      end else begin
        if (prev_hold[k]) check_eq("hold_valid", 32'(rd_valid[k]), 1);
        if (rd_valid[k]) begin
          if (q_size(k) == 0) begin
            check_eq("spurious_beat", q_size(k), 1);
          end else begin
            check_eq("rd_data", rd_data[k], q_front(k));
            if (rd_ready[k]) q_drop(k);
          end
          if (rd_ready[k]) pops[k]++;
        end
        prev_hold[k] = rd_valid[k] && !rd_ready[k];
        if (rd_req_valid[k] && rd_req_ready[k]) begin
          e = mm[k][rd_addr[k]];
          if (k == 1 && wr_en[k] && wr_addr[k] == rd_addr[k]) begin
            for (int l = 0; l < NB; l++)
              if (wr_be[k][l]) e[l*8 +: 8] = wr_data[k][l*8 +: 8];
          end
          q_push(k, e);
        end
        if (wr_en[k]) begin
          for (int l = 0; l < NB; l++)
            if (wr_be[k][l]) mm[k][wr_addr[k]][l*8 +: 8] = wr_data[k][l*8 +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int k, input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en[k] = 1'b1; wr_addr[k] = a; wr_be[k] = be; wr_data[k] = d;
    tick();
    wr_en[k] = 1'b0;
  endtask

  task automatic drain(input int k, input string tag);
    rd_ready[k] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q_size(k) == 0 && !rd_valid[k]) break;
      tick();
    end
    check_eq({tag, "_drained"}, q_size(k), 0);
    tick();
  endtask

  // single read with latency, data and single-beat checks; optional same-edge write
  task automatic read_check(input int k, input logic [3:0] a, input logic [31:0] exp,
                            input string tag, input bit with_wr, input logic [31:0] wdata);
    int lat;
    lat = 0;
    rd_ready[k] = 1'b1; rd_req_valid[k] = 1'b1; rd_addr[k] = a;
    if (with_wr) begin
      wr_en[k] = 1'b1; wr_addr[k] = a; wr_be[k] = 4'hF; wr_data[k] = wdata;
    end
    @(negedge clk);
    check_eq({tag, "_req_ready"}, 32'(rd_req_ready[k]), 1);
    tick();
    rd_req_valid[k] = 1'b0; wr_en[k] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (rd_valid[k]) begin
        lat = j;
        break;
      end
      tick();
    end
    check_eq({tag, "_latency"}, lat, lat_of(k));
    check_eq({tag, "_data"}, rd_data[k], exp);
    tick();
    @(negedge clk);
    check_eq({tag, "_single_beat"}, 32'(rd_valid[k]), 0);
    tick();
  endtask

  task automatic run_suite(input int k);
    int L;
    int acc;
    int p0;
    int first;
    int cnt;
    int last;
    logic [31:0] vmask;
    L = lat_of(k);

    do_write(k, 4'd3, 4'hF, 32'hDEADBEEF);
    read_check(k, 4'd3, 32'hDEADBEEF, "t1", 1'b0, 32'h0);

    do_write(k, 4'd5, 4'hF, 32'h11223344);
    do_write(k, 4'd5, 4'b0101, 32'hAABBCCDD);
    read_check(k, 4'd5, 32'h11BB33DD, "t2", 1'b0, 32'h0);

    do_write(k, 4'd7, 4'hF, 32'h12345678);
    read_check(k, 4'd7, (k == 0) ? 32'h12345678 : 32'h0000FFFF, "t3_rdw", 1'b1, 32'h0000FFFF);

    for (int a = 0; a < 8; a++) do_write(k, 4'(a), 4'hF, 32'(a * 32'h101));
    rd_ready[k] = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      rd_req_valid[k] = 1'b1; rd_addr[k] = 4'(acc);
      @(negedge clk);
      if (rd_req_ready[k]) acc++;
      tick();
    end
    check_eq("t4_accepted_stalled", acc, L + 1);
    @(negedge clk);
    check_eq("t4_req_ready_full", 32'(rd_req_ready[k]), 0);
    tick();
    p0 = pops[k];
    rd_ready[k] = 1'b1;
    for (int i = 0; i < 40 && acc < 8; i++) begin
      rd_addr[k] = 4'(acc);
      @(negedge clk);
      if (rd_req_ready[k]) acc++;
      tick();
    end
    rd_req_valid[k] = 1'b0;
    drain(k, "t4");
    check_eq("t4_accepted_total", acc, 8);
    check_eq("t4_beats", pops[k] - p0, 8);

    for (int a = 0; a < 16; a++) do_write(k, 4'(a), 4'hF, 32'(a * 32'h01010101));
    rd_ready[k] = 1'b1;
    vmask = '0;
    for (int i = 0; i < 24; i++) begin
      rd_req_valid[k] = (i < 16); rd_addr[k] = 4'(i);
      @(negedge clk);
      if (i < 16) check_eq("t5_req_ready", 32'(rd_req_ready[k]), 1);
      vmask[i] = rd_valid[k];
      tick();
    end
    rd_req_valid[k] = 1'b0;
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (vmask[i]) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    check_eq("t5_first_beat", first, L);
    check_eq("t5_beats", cnt, 16);
    check_eq("t5_contiguous", last - first + 1, 16);
    drain(k, "t5");

    rd_ready[k] = 1'b0;
    acc = 0;
    for (int i = 0; i < 10 && acc < L + 1; i++) begin
      rd_req_valid[k] = 1'b1; rd_addr[k] = 4'(acc);
      @(negedge clk);
      if (rd_req_ready[k]) acc++;
      tick();
    end
    rd_req_valid[k] = 1'b0;
    check_eq("t6_outstanding", acc, L + 1);
    @(negedge clk);
    check_eq("t6_valid_before_rst", 32'(rd_valid[k]), 1);
    tick();
    rst[k] = 1'b1;
    wr_en[k] = 1'b1; wr_addr[k] = 4'd3; wr_be[k] = 4'hF; wr_data[k] = 32'hBAD0BAD0;
    tick();
    rst[k] = 1'b0; wr_en[k] = 1'b0;
    @(negedge clk);
    check_eq("t6_valid_after_rst", 32'(rd_valid[k]), 0);
    check_eq("t6_ready_after_rst", 32'(rd_req_ready[k]), 1);
    tick();
    rd_ready[k] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("t6_no_ghost", 32'(rd_valid[k]), 0);
      tick();
    end
    read_check(k, 4'd3, 32'h03030303, "t6_retained", 1'b0, 32'h0);
  endtask

  initial begin
    rst = 2'b11; wr_en = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_req_valid = '0; rd_addr = '0; rd_ready = '0;
    repeat (3) tick();
    rst = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_req_ready", 32'(rd_req_ready[k]), 1);
      check_eq("reset_rd_valid", 32'(rd_valid[k]), 0);
      check_eq("reset_rd_data", rd_data[k], 0);
    end
    tick();
    for (int k = 0; k < 2; k++) run_suite(k);
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
